// File: rtl/aq_axi_sdma64_slave_mem.sv
// 64-bit AXI4 slave backed by a dual-port RAM: independent write and read FSMs,
// INCR bursts up to 256 beats, one outstanding transaction per channel.
module aq_axi_sdma64_slave_mem #(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int unsigned WA    = ADDR_BITS - 3;
    localparam int unsigned DEPTH = 1 << WA;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [63:0] mem [DEPTH];

    w_state_t     w_state;
    logic [WA-1:0] w_addr;
    logic [7:0]   w_cnt;
    logic         w_err;
    logic         w_fire;

    r_state_t     r_state;
    logic [WA-1:0] r_addr;
    logic [7:0]   r_cnt;
    logic         r_err;

    // Upper address bits alias and the byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[31:ADDR_BITS], S_AXI_AWADDR[2:0],
                                S_AXI_ARADDR[31:ADDR_BITS], S_AXI_ARADDR[2:0]};

    always_comb begin
        w_fire = (w_state == W_DATA) && S_AXI_WVALID;
    end

    always_ff @(posedge ACLK) begin
        if (w_fire && !w_err) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (S_AXI_WSTRB[i]) mem[w_addr][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state       <= W_IDLE;
            w_addr        <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_BID     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID) begin
                        w_addr        <= S_AXI_AWADDR[ADDR_BITS-1:3];
                        w_cnt         <= S_AXI_AWLEN;
                        S_AXI_BID     <= S_AXI_AWID;
                        w_err         <= (S_AXI_AWSIZE != 3'b011) || (S_AXI_AWBURST != 2'b01);
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        w_addr <= w_addr + WA'(1);
                        if (w_cnt == 8'd0) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (w_err || !S_AXI_WLAST) ? 2'b10 : 2'b00;
                            w_state      <= W_RESP;
                        end else begin
                            // Early WLAST poisons the rest of the burst but keeps counting beats.
                            if (S_AXI_WLAST) w_err <= 1'b1;
                            w_cnt <= w_cnt - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= R_IDLE;
            r_addr        <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RID     <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_addr        <= S_AXI_ARADDR[ADDR_BITS-1:3];
                        r_cnt         <= S_AXI_ARLEN;
                        S_AXI_RID     <= S_AXI_ARID;
                        r_err         <= (S_AXI_ARSIZE != 3'b011) || (S_AXI_ARBURST != 2'b01);
                        S_AXI_ARREADY <= 1'b0;
                        r_state       <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    S_AXI_RDATA  <= mem[r_addr];
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RLAST  <= (r_cnt == 8'd0);
                    S_AXI_RRESP  <= r_err ? 2'b10 : 2'b00;
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        S_AXI_RLAST  <= 1'b0;
                        if (S_AXI_RLAST) begin
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_addr  <= r_addr + WA'(1);
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aq_axi_sdma64_slave_mem.sv
// Randomized bench for aq_axi_sdma64_slave_mem against a word-array memory model
// and per-channel expected-response queues.
module tb_aq_axi_sdma64_slave_mem;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awid, awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bid, bvalid, bready;
    logic [1:0]  bresp;
    logic        arid, arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rid, rlast, rvalid, rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    aq_axi_sdma64_slave_mem #(.ADDR_BITS(12)) dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic        id;
        logic [1:0]  resp;
        logic        last;
        logic [63:0] data;
    } rbeat_t;

    int total = 0;
    int bad = 0;
    logic [63:0] model_mem [512];
    logic [63:0] wb_data [256];
    logic [7:0]  wb_strb [256];
    rbeat_t      exp_r [$];
    logic [2:0]  exp_b [$];
    logic [63:0] last_rdata;
    logic [1:0]  last_rresp;
    logic [1:0]  last_bresp;
    logic        prev_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    function automatic void model_write(input int w, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Response checker: every cycle a response is presented it must match the queue head.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !rvalid) begin
                total++;
                bad++;
                $display("FAIL r_hold: got rvalid=0 expected rvalid=1");
            end
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL r_unexpected: got rvalid=1 expected rvalid=0");
                end else begin
                    check("rdata", rdata, exp_r[0].data);
                    check("rctl{id,resp,last}", {rid, rresp, rlast},
                          {exp_r[0].id, exp_r[0].resp, exp_r[0].last});
                    if (rready) begin
                        last_rdata = rdata;
                        last_rresp = rresp;
                        void'(exp_r.pop_front());
                    end
                end
            end
            prev_stall = rvalid && !rready;
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected: got bvalid=1 expected bvalid=0");
                end else begin
                    check("b{id,resp}", {bid, bresp}, exp_b[0]);
                    if (bready) begin
                        last_bresp = bresp;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input logic id, input int early,
                               input bit gaps);
        bit cfg_err;
        int base;
        int n;
        cfg_err = (size != 3'b011) || (burst != 2'b01);
        base = int'(addr[11:3]);
        for (int i = 0; i <= len; i++)
            if (!cfg_err && (early < 0 || i <= early)) model_write((base + i) % 512, wb_data[i], wb_strb[i]);
        exp_b.push_back({id, (cfg_err || early >= 0) ? 2'b10 : 2'b00});
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awid = id;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 300);
        if (!awready) timeout_fail("aw_handshake");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                cyc(1);
            end
            wvalid = 1'b1; wdata = wb_data[i]; wstrb = wb_strb[i];
            wlast = (i == len) || (i == early);
            n = 0;
            do begin @(negedge aclk); n++; end while (!wready && n < 300);
            if (!wready) timeout_fail("w_handshake");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (gaps) cyc($urandom_range(0, 3));
        bready = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bvalid && n < 300);
        if (!bvalid) timeout_fail("b_handshake");
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // mode 0: random RREADY, 1: always ready, 2: RREADY held low 5 cycles mid-burst
    task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input logic id, input int mode);
        bit cfg_err;
        bit stalled;
        int base;
        int n;
        rbeat_t e;
        cfg_err = (size != 3'b011) || (burst != 2'b01);
        base = int'(addr[11:3]);
        for (int i = 0; i <= len; i++) begin
            e.id = id;
            e.resp = cfg_err ? 2'b10 : 2'b00;
            e.last = (i == len);
            e.data = model_mem[(base + i) % 512];
            exp_r.push_back(e);
        end
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arid = id;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 300);
        if (!arready) timeout_fail("ar_handshake");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready = (mode != 0);
        @(negedge aclk);
        check("r_latency_fetch", {63'b0, rvalid}, 64'd0);
        @(negedge aclk);
        check("r_latency_data", {63'b0, rvalid}, 64'd1);
        n = 0;
        stalled = 1'b0;
        while (exp_r.size() > 0 && n < 3000) begin
            @(posedge aclk); #1;
            n++;
            if (mode == 0) rready = ($urandom_range(0, 2) != 0);
            else if (mode == 2 && !stalled && exp_r.size() <= (len + 1) / 2) begin
                stalled = 1'b1;
                rready = 1'b0;
                cyc(5);
                rready = 1'b1;
            end else rready = 1'b1;
        end
        if (exp_r.size() > 0) begin
            timeout_fail("r_drain");
            exp_r.delete();
        end
        rready = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int len, early, word;
        aresetn = 1'b0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3; awburst = 1; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 3; arburst = 1; arvalid = 0; rready = 0;
        #12;
        check("rst_awready", {63'b0, awready}, 64'd1);
        check("rst_arready", {63'b0, arready}, 64'd1);
        check("rst_wready_bvalid_rvalid_rlast", {60'b0, wready, bvalid, rvalid, rlast}, 64'd0);
        check("rst_resp_ids", {58'b0, bresp, rresp, bid, rid}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        cyc(2);

        wb_data[0] = 64'h1122334455667788; wb_strb[0] = 8'hFF;
        write_burst(32'h10, 0, 3'b011, 2'b01, 1'b1, -1, 1'b0);
        check("single_bresp", {62'b0, last_bresp}, 64'd0);
        read_burst(32'h10, 0, 3'b011, 2'b01, 1'b0, 1);
        check("single_rdata", last_rdata, 64'h1122334455667788);

        for (int i = 0; i < 256; i++) begin wb_data[i] = 64'(i); wb_strb[i] = 8'hFF; end
        write_burst(32'h0, 255, 3'b011, 2'b01, 1'b0, -1, 1'b0);
        read_burst(32'h0, 255, 3'b011, 2'b01, 1'b1, 1);
        check("burst256_last", last_rdata, 64'd255);
        for (int i = 0; i < 256; i++) begin wb_data[i] = {$urandom, $urandom}; wb_strb[i] = 8'hFF; end
        write_burst(32'h800, 255, 3'b011, 2'b01, 1'b1, -1, 1'b1);

        wb_data[0] = '1; wb_strb[0] = 8'hFF;
        write_burst(32'h40, 0, 3'b011, 2'b01, 1'b0, -1, 1'b0);
        wb_data[0] = '0; wb_strb[0] = 8'h0F;
        write_burst(32'h40, 0, 3'b011, 2'b01, 1'b0, -1, 1'b0);
        read_burst(32'h40, 0, 3'b011, 2'b01, 1'b0, 1);
        check("strobe_rdata", last_rdata, 64'hFFFF_FFFF_0000_0000);

        wb_data[0] = 64'hA0A0_A0A0_A0A0_A0A0; wb_data[1] = 64'hB0B0_B0B0_B0B0_B0B0;
        wb_strb[0] = 8'hFF; wb_strb[1] = 8'hFF;
        write_burst(32'hFF8, 1, 3'b011, 2'b01, 1'b1, -1, 1'b0);
        read_burst(32'h000, 0, 3'b011, 2'b01, 1'b1, 1);
        check("wrap_word0", last_rdata, 64'hB0B0_B0B0_B0B0_B0B0);
        read_burst(32'h1_0FF8, 0, 3'b011, 2'b01, 1'b0, 1);
        check("alias_word511", last_rdata, 64'hA0A0_A0A0_A0A0_A0A0);

        for (int i = 0; i < 4; i++) begin wb_data[i] = {$urandom, $urandom}; wb_strb[i] = 8'hFF; end
        write_burst(32'h300, 3, 3'b011, 2'b01, 1'b0, 1, 1'b0);
        check("early_wlast_bresp", {62'b0, last_bresp}, 64'd2);
        read_burst(32'h300, 3, 3'b011, 2'b01, 1'b0, 0);

        wb_data[0] = 64'hCAFE_F00D_1234_5678; wb_strb[0] = 8'hFF;
        write_burst(32'h200, 0, 3'b011, 2'b01, 1'b0, -1, 1'b0);
        wb_data[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        write_burst(32'h200, 0, 3'b011, 2'b10, 1'b1, -1, 1'b0);
        check("badburst_bresp", {62'b0, last_bresp}, 64'd2);
        read_burst(32'h200, 0, 3'b011, 2'b01, 1'b0, 1);
        check("badburst_nowrite", last_rdata, 64'hCAFE_F00D_1234_5678);

        read_burst(32'h400, 5, 3'b010, 2'b01, 1'b1, 0);
        check("badsize_rresp", {62'b0, last_rresp}, 64'd2);

        read_burst(32'h0, 15, 3'b011, 2'b01, 1'b0, 2);

        for (int i = 0; i < 8; i++) begin wb_data[i] = {$urandom, $urandom}; wb_strb[i] = 8'hFF; end
        awvalid = 1'b1; awaddr = 32'h100; awlen = 8'd7; awsize = 3; awburst = 1; awid = 1;
        do @(negedge aclk); while (!awready);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = wb_data[i]; wstrb = 8'hFF; wlast = 1'b0;
            @(negedge aclk);
            if (!wready) timeout_fail("rst_burst_wready");
            @(posedge aclk); #1;
            model_write(32 + i, wb_data[i], 8'hFF);
        end
        wvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("midrst_awready", {63'b0, awready}, 64'd1);
        check("midrst_bvalid_wready", {62'b0, bvalid, wready}, 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        cyc(2);
        read_burst(32'h100, 7, 3'b011, 2'b01, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin wb_data[i] = {$urandom, $urandom}; wb_strb[i] = 8'hFF; end
        write_burst(32'h100, 2, 3'b011, 2'b01, 1'b1, -1, 1'b1);
        check("postrst_bresp", {62'b0, last_bresp}, 64'd0);

        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 2);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) begin
                wb_data[i] = {$urandom, $urandom};
                wb_strb[i] = 8'($urandom);
            end
            if (op == 2) begin
                len = len % 16;
                word = $urandom_range(0, 240);
                a = ($urandom & 32'hFFFF_F000) | 32'(word << 3) | ($urandom & 32'h7);
                word = $urandom_range(256, 496);
                fork
                    write_burst(a, len, 3'b011, 2'b01, 1'($urandom), -1, 1'b1);
                    read_burst(($urandom & 32'hFFFF_F000) | 32'(word << 3), $urandom_range(0, 15),
                               3'b011, 2'b01, 1'($urandom), 0);
                join
            end else begin
                a = $urandom;
                early = (len > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
                if (op == 0)
                    write_burst(a, len, ($urandom_range(0, 7) == 0) ? 3'b010 : 3'b011,
                                ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01, 1'($urandom), early, 1'b1);
                else
                    read_burst(a, len, 3'b011, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01,
                               1'($urandom), 0);
            end
        end
        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aq_axi_sdma64_slave_mem.md
Name: aq_axi_sdma64_slave_mem

Overview:
- 64-bit AXI4 slave (responder) backed by an internal dual-port RAM.
- Serves as the memory-side endpoint for the SDMA64 master in block-level and subsystem simulation, and as a small on-chip scratch buffer.
- Accepts INCR bursts of up to 256 beats on independent write and read channels.
- Each channel has at most one outstanding transaction.

Parameters:
- ADDR_BITS, 12: byte-address bits decoded. Depth is 2^(ADDR_BITS-3) 64-bit words. Higher address bits are ignored, so the memory aliases.

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWID  in  1  write ID
- S_AXI_AWADDR  in  32  write byte address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  must be 3'b011
- S_AXI_AWBURST  in  2  must be 2'b01
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  64  write data
- S_AXI_WSTRB  in  8  byte enables
- S_AXI_WLAST  in  1  last write beat
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BID  out  1  echoes latched AWID
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  response valid
- S_AXI_BREADY  in  1  response ready
- S_AXI_ARID  in  1  read ID
- S_AXI_ARADDR  in  32  read byte address
- S_AXI_ARLEN  in  8  beats-1
- S_AXI_ARSIZE  in  3  must be 3'b011
- S_AXI_ARBURST  in  2  must be 2'b01
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RID  out  1  echoes latched ARID
- S_AXI_RDATA  out  64  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - Both FSMs go to idle.
  - AWREADY=1, ARREADY=1.
  - WREADY, BVALID, RVALID and RLAST = 0.
  - BRESP, RRESP = 2'b00. BID, RID, RDATA = 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst. Beats already written stay written.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID, latch word address = AWADDR[ADDR_BITS-1:3], beat counter = AWLEN, AWID, and err = (AWSIZE!=3 | AWBURST!=1). Go to W_DATA. AWADDR[2:0] is ignored.
  - W_DATA: WREADY=1. On each WVALID&WREADY:
    - If !err, write the RAM word with per-byte WSTRB enables.
    - Word address increments by 1 and wraps modulo depth.
    - On the beat where counter==0: set err |= !WLAST, then go to W_RESP.
    - On an earlier beat with WLAST=1: set err=1, decrement the counter and continue until counter==0.
    - Otherwise decrement the counter.
  - W_RESP: BVALID=1, BRESP = err ? 2'b10 : 2'b00, BID = latched ID. On BREADY, go to W_IDLE. AWREADY rises in the following cycle.
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID, latch word address, counter = ARLEN, ARID, and err (same rule as write). Go to R_FETCH.
  - R_FETCH: issue a synchronous RAM read (1-cycle latency), then go to R_DATA.
  - R_DATA: RVALID=1 with RDATA registered. RRESP = err ? 2'b10 : 2'b00. When err=1, RDATA is still the RAM contents. RLAST = (counter==0).
  - RDATA, RLAST and RRESP are held stable while RVALID&!RREADY.
  - On handshake: if RLAST, go to R_IDLE. Otherwise decrement the counter, increment the address with wrap, and go to R_FETCH.
  - Throughput is 1 beat per 2 cycles. ARVALID→first RVALID latency is 2 cycles.
- Simultaneous events:
  - Write and read channels run fully concurrently.
  - Read and write to the same word in the same cycle returns the old data (read-first).
- First beat of a burst: AW and W may not be accepted in the same cycle. WREADY asserts the cycle after the AW handshake.

Test Plan:
- Single-beat write: AWADDR=0x10, AWLEN=0, WDATA=0x1122334455667788, WSTRB=0xFF → BRESP=00, BID=AWID. A subsequent read of 0x10 with ARLEN=0 returns that data with RLAST=1.
- 256-beat write at 0x0 with data=beat index, then a 256-beat read → 256 RDATA beats 0..255, RLAST only on beat 255, RRESP=00.
- Byte strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with WSTRB=0x0F → read returns 0xFFFF_FFFF_0000_0000.
- Wrap: ADDR_BITS=12, write AWADDR=0xFF8 with AWLEN=1 → second beat lands at word 0. A read at 0x000 returns it.
- Protocol errors:
  - Early WLAST on beat 2 of AWLEN=3 → BRESP=10 after the 4th beat.
  - AWBURST=2'b10 → no RAM write, BRESP=10.
  - ARSIZE=2 → RRESP=10 on all beats.
- Backpressure and reset:
  - RREADY low for 5 cycles mid-burst → RDATA/RLAST stable, no beat lost.
  - ARESETN pulsed low during a write burst → AWREADY=1, BVALID=0 immediately.
  - A new burst after reset completes with BRESP=00.
